// File: rtl/onehot_decoder_sequencer.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a single-decode mode and a
// dwell-timed upward scan mode, fed through a valid/ready request port.
module onehot_decoder_sequencer #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_mode,
  input  logic [SEL_W-1:0]   req_sel,
  output logic [(1<<SEL_W)-1:0] out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N      = 1 << SEL_W;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_TOP    = SEL_W'(N - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [N-1:0]       out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;

  // One-hot encode an index; the shift amount never exceeds N-1.
  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    return N'(1) << i;
  endfunction

  // Ready only when enabled and not already scanning.
  assign req_ready = en && (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; en low overrides everything and aborts any scan silently.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      dwell_d = '0;
      out_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_d = onehot(req_sel);
            if (req_mode) begin
              idx_d   = req_sel;
              dwell_d = '0;
              state_d = ST_SCAN;
              busy_d  = 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (dwell_q != DWELL_LAST) begin
            dwell_d = dwell_q + CNT_W'(1);
          end else if (idx_q != IDX_TOP) begin
            idx_d   = idx_q + SEL_W'(1);
            out_d   = onehot(idx_q + SEL_W'(1));
            dwell_d = '0;
          end else begin
            out_d   = '0;
            dwell_d = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/onehot_decoder_sequencer.md
# onehot_decoder_sequencer

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready request port and two modes:
- **Single-decode**: latches one selected output.
- **Scan**: steps the one-hot output from a start index up to the top index, holding each position for DWELL cycles.

It drives per-unit select and enable lines (bank/row enables, mux selects) from controller logic. The output is glitch-free because it comes from a register rather than from a gate network.

## Interface
Parameters:
- SEL_W, default 2: select width; the output is 2^SEL_W bits (N = 2^SEL_W). Legal range 1..6.
- DWELL, default 1: cycles each position is held in scan mode. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; clears all state immediately.
- en  input  1  block enable; when low, activity is aborted and the output is cleared (synchronous).
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted; combinational, equals en AND (state == IDLE).
- req_mode  input  1  0 = single-decode, 1 = scan.
- req_sel  input  SEL_W  index to decode (single mode) or start index (scan mode).
- out  output  N  registered one-hot output, or all zeros.
- busy  output  1  registered; high while in the SCAN state.
- done  output  1  registered one-cycle pulse marking scan completion.

## Operation
- **States**: IDLE and SCAN. Internal registers are idx (SEL_W bits) and dwell_cnt (8 bits).
- **Acceptance**: a request is accepted on an edge where req_valid AND req_ready are both high.
- **IDLE, accepting req_mode=0**: out <= one-hot(req_sel). The state stays IDLE. out holds this value until the next accepted request, an en drop, or reset.
- **IDLE, accepting req_mode=1**:
  - out <= one-hot(req_sel), idx <= req_sel, dwell_cnt <= 0.
  - State moves to SCAN and busy <= 1.
- **IDLE, no acceptance**: out holds its value; done <= 0.
- **SCAN, each edge with dwell_cnt < DWELL-1**: dwell_cnt increments and out holds.
- **SCAN, dwell_cnt == DWELL-1 and idx < N-1**: idx increments, out shifts one position up (one-hot(idx+1)), dwell_cnt <= 0.
- **SCAN, dwell_cnt == DWELL-1 and idx == N-1**: out <= 0, done <= 1 for exactly one cycle, busy <= 0, state moves to IDLE.
- **Scan length**: a scan visits N - req_sel positions. There is no wrap-around past N-1; idx never overflows.
- **No re-triggering**: req_ready is low throughout SCAN, so requests presented then are not accepted. The requester must keep req_valid asserted until acceptance.
- **en low on any edge**:
  - Takes priority over everything else.
  - out <= 0, busy <= 0, done <= 0, dwell_cnt <= 0, state moves to IDLE.
  - A scan aborted this way never produces done.
- **Output invariant**: out is always either all zeros or exactly one bit set. There is no X and no multi-hot value.

## Timing
- **Reset** (reset_n low, asynchronous): out=0, busy=0, done=0, state=IDLE, idx=0, dwell_cnt=0. req_ready then equals en.
- **Single-decode latency**: request accepted at edge k; out is valid from edge k onward, i.e. visible in cycle k+1.
- **Scan from start s**: out=one-hot(s) from the accept edge for DWELL cycles, then each higher index for DWELL cycles. Total scan time is (N-s)×DWELL cycles after acceptance.
- **Completion**: in the cycle following the last dwell, done=1, out=0 and req_ready=1 (when en=1). A request accepted in that cycle starts on the same edge that clears done, so back-to-back operation has no idle cycle.
- **Reset mid-scan**: all outputs clear immediately. The first legal accept is the first edge after reset_n deasserts.

## Test plan
- **Reset and single-decode**: reset_n low with out nonzero -> out=0, busy=0, done=0 immediately. Release, en=1, single-decode req_sel=2 -> out=0100 after one edge; out holds 0100 through 10 idle cycles.
- **Scan, SEL_W=2, DWELL=2, req_sel=1**: out=0010 ×2, 0100 ×2, 1000 ×2 cycles, then one cycle of out=0000 with done=1. busy is high for exactly 6 cycles.
- **Scan from top index**: req_sel=3, DWELL=1 -> out=1000 for 1 cycle, then done=1. req_valid held during the scan -> req_ready=0 and no acceptance until the done cycle.
- **Back-to-back**: single-decode req_sel=0 presented in the done cycle -> accepted on that edge; out=0001 the next cycle, done=0.
- **Abort**: drop en for one cycle mid-scan -> out=0 and busy=0 on the next edge, done never pulses, req_ready=0 while en=0. After restoring en, a new request is accepted normally.
- **Sweep**: SEL_W=3, DWELL=3, all 8 start indices -> the one-hot invariant holds on every cycle, scan length is (8-s)×3 cycles, and done fires exactly once per scan.
